// File: rtl/intersection_phase_scheduler.sv
// Intersection phase scheduler: one green at a time, yellow and all-red clearance.
// Optional macro PREEMPT_EN adds the preempt/preempt_id override ports.
module intersection_phase_scheduler #(
  parameter int NUM_APPR  = 4,
  parameter int TICK_DIV  = 4,
  parameter int TW        = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_APPR-1:0]         sensor,
`ifdef PREEMPT_EN
  input  logic                        preempt,
  input  logic [$clog2(NUM_APPR)-1:0] preempt_id,
`endif
  output logic [2*NUM_APPR-1:0]       signal,
  output logic [$clog2(NUM_APPR)-1:0] green_id,
  output logic [1:0]                  phase_state,
  output logic                        switch_pulse
);

  localparam int IW = $clog2(NUM_APPR);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = IW + 1;

  localparam logic [1:0] S_GREEN = 2'b00;
  localparam logic [1:0] S_YEL   = 2'b01;
  localparam logic [1:0] S_AR    = 2'b10;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] MIN_T     = TW'(MIN_GREEN);
  localparam logic [TW-1:0] MAX_T     = TW'(MAX_GREEN);
  localparam logic [TW-1:0] YEL_T     = TW'(YELLOW_T);
  localparam logic [TW-1:0] AR_T      = TW'(ALL_RED_T);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         green_q, green_d;
  logic [IW-1:0]         next_q, next_d, next_eff;
  logic [IW-1:0]         rr_id, rr_idx;
  logic [NUM_APPR-1:0]   sensor_q, req_q, req_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [TW-1:0]         timer_q, timer_d, timer_inc;
  logic [2*NUM_APPR-1:0] signal_q, signal_d;
  logic [1:0]            phase_q, phase_d;
  logic                  pulse_q, pulse_d;
  logic [BW-1:0]         base;
  logic                  tick, rr_any, go_yel, enter_green;
  logic                  pre_act;
  logic [IW-1:0]         pre_id;

`ifdef PREEMPT_EN
  logic          preempt_q;
  logic [IW-1:0] pid_q;

  // Register the preempt request alongside the sensors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      preempt_q <= 1'b0;
      pid_q     <= '0;
    end else begin
      preempt_q <= preempt;
      pid_q     <= preempt_id;
    end
  end

  assign pre_act = preempt_q;
  assign pre_id  = pid_q;
`else
  assign pre_act = 1'b0;
  assign pre_id  = '0;
`endif

  // Tick strobe and saturating count of ticks completed including this one.
  always_comb begin
    tick      = (presc_q == TICK_LAST);
    timer_inc = (&timer_q) ? timer_q : timer_q + TW'(1);
  end

  // Round-robin search from green+1 upward, wrapping, skipping green.
  always_comb begin
    rr_any = 1'b0;
    rr_id  = green_q;
    rr_idx = '0;
    for (int k = NUM_APPR - 1; k >= 1; k--) begin
      rr_idx = IW'((int'(green_q) + k) % NUM_APPR);
      if (req_q[rr_idx]) begin
        rr_any = 1'b1;
        rr_id  = rr_idx;
      end
    end
  end

  // Green exit decision, taken only on a tick boundary.
  always_comb begin
    go_yel = 1'b0;
    if (tick) begin
      if (pre_act)
        go_yel = (green_q != pre_id);
      else
        go_yel = (timer_inc >= MIN_T) && rr_any &&
                 (!sensor_q[green_q] || timer_inc >= MAX_T);
    end
  end

  // Next-state logic; unknown encodings fall back to all-red.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GREEN: if (go_yel) state_d = S_YEL;
      S_YEL:   if (tick && timer_inc >= YEL_T) state_d = S_AR;
      S_AR:    if (tick && timer_inc >= AR_T) state_d = S_GREEN;
      default: state_d = S_AR;
    endcase
  end

  // Grant bookkeeping, demand latches and interval counters.
  always_comb begin
    enter_green = (state_q == S_AR) && (state_d == S_GREEN);
    next_eff    = pre_act ? pre_id : next_q;
    next_d      = next_q;
    if (state_q == S_GREEN && state_d == S_YEL) next_d = rr_id;
    if (pre_act) next_d = pre_id;
    green_d = enter_green ? next_eff : green_q;
    req_d   = req_q | sensor_q;
    if (enter_green) req_d[green_d] = 1'b0;
    presc_d = presc_q + PW'(1);
    timer_d = timer_q;
    if (state_d != state_q) begin
      presc_d = '0;
      timer_d = '0;
    end else if (tick) begin
      presc_d = '0;
      timer_d = timer_inc;
    end
  end

  // Output decode from the upcoming state so outputs register with it.
  always_comb begin
    signal_d = '1;
    base     = {green_d, 1'b0};
    phase_d  = state_d;
    pulse_d  = enter_green;
    if (state_d == S_GREEN)
      signal_d[base +: 2] = 2'b01;
    else if (state_d == S_YEL)
      signal_d[base +: 2] = 2'b10;
  end

  // State, counters, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_AR;
      green_q  <= '0;
      next_q   <= '0;
      sensor_q <= '0;
      req_q    <= '0;
      presc_q  <= '0;
      timer_q  <= '0;
      signal_q <= '1;
      phase_q  <= S_AR;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      green_q  <= green_d;
      next_q   <= next_d;
      sensor_q <= sensor;
      req_q    <= req_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      signal_q <= signal_d;
      phase_q  <= phase_d;
      pulse_q  <= pulse_d;
    end
  end

  assign signal       = signal_q;
  assign green_id     = green_q;
  assign phase_state  = phase_q;
  assign switch_pulse = pulse_q;

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a multi-approach intersection: grants green to one approach at a time.
- Runs yellow and all-red clearance intervals between greens.
- Chooses the next approach round-robin among approaches with latched demand.
- Drives per-approach 2-bit signal heads using the existing encoding: 01 green, 10 yellow, 11 red; 00 is never driven.

Parameters:
- NUM_APPR, 4, number of approaches (2..8).
- TICK_DIV, 4, clk cycles per timing tick (>=2).
- TW, 8, width of tick timer.
- MIN_GREEN, 4, minimum green in ticks (>=1).
- MAX_GREEN, 12, maximum green under competing demand in ticks (>MIN_GREEN).
- YELLOW_T, 3, yellow interval in ticks (>=1).
- ALL_RED_T, 1, all-red clearance in ticks (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- sensor  input  NUM_APPR  per-approach vehicle demand, level.
- signal  output  2*NUM_APPR  signal head of approach i at bits [2i+1:2i].
- green_id  output  $clog2(NUM_APPR)  approach currently granted or last granted.
- phase_state  output  2  00 GREEN, 01 YELLOW, 10 ALL_RED.
- switch_pulse  output  1  one-cycle pulse on each new green start.

Behaviour:
- Reset, sampled with rst=0 at a clk edge:
  - state=ALL_RED, next_id=0, green_id=0.
  - All signal fields 11; switch_pulse=0.
  - Demand latches, prescaler and tick timer cleared.
- Inputs: sensor is registered once (sensor_q), giving 1 cycle of input latency. req[i] sets when sensor_q[i]=1 and clears when approach i enters GREEN; set wins over clear except for the approach entering GREEN that cycle.
- Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1. Prescaler and tick timer restart at 0 on every state change, so each state lasts exactly (ticks x TICK_DIV) cycles.
- Outputs are registered and change on the same edge as the state register.
- GREEN:
  - signal[green_id]=01, all others 11.
  - Exit to YELLOW at a tick boundary when timer>=MIN_GREEN and some other req[j]=1, and either sensor_q[green_id]=0 or timer>=MAX_GREEN.
  - With no competing demand, hold green indefinitely. The timer saturates at 2^TW-1.
- Entering YELLOW: next_id = first j with req[j]=1, searching green_id+1 upward with wrap-around modulo NUM_APPR and excluding green_id. It is latched and not re-evaluated.
- YELLOW: signal[green_id]=10, others 11. After YELLOW_T ticks go to ALL_RED.
- ALL_RED: all 11. After ALL_RED_T ticks go to GREEN with green_id=next_id, and pulse switch_pulse for 1 cycle.
- Boundary cases:
  - Simultaneous demands are resolved by round-robin order only.
  - Demand arriving during YELLOW or ALL_RED is latched and served in a later cycle.
  - Reset mid-phase enters ALL_RED at once with no yellow.
  - Never more than one field is non-11.
  - Illegal state is recovered to ALL_RED with all 11.

Optional Feature:
- Macro: PREEMPT_EN.
- When defined, adds ports preempt (input, 1) and preempt_id (input, $clog2(NUM_APPR)), both registered once.
- While preempt_q=1:
  - GREEN on preempt_id holds green, ignoring MAX_GREEN.
  - GREEN on another approach goes to YELLOW at the next tick, ignoring MIN_GREEN.
  - next_id is forced to preempt_id in every state, including an in-progress YELLOW or ALL_RED.
  - Clearance intervals are never shortened.
- When undefined, the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset, then rst=1 with no sensors -> all 11 for 4 cycles; then signal[1:0]=01, switch_pulse=1 for 1 cycle, green_id=0; held green for 200 cycles.
- Approach 0 green past MIN_GREEN, sensor[2] pulsed for 1 cycle with sensor[0]=0 -> signal[1:0]=10 at the next tick. It holds 12 cycles, then all 11 for 4 cycles, then signal[5:4]=01, green_id=2.
- sensor[0]=1 held plus sensor[1]=1 -> approach 0 stays green exactly 48 cycles (MAX_GREEN), then yellow 12 cycles, all-red 4, approach 1 green.
- green_id=2, req[1] and req[3] set together -> next green is 3; afterwards with req[1] still pending -> 1.
- rst=0 asserted mid-YELLOW -> next edge all 11, phase_state=10; after release, approach 0 green after 4 cycles.
- PREEMPT_EN: approach 0 green at timer=1, preempt=1 with preempt_id=3 -> yellow at next tick (before MIN_GREEN), then all-red, then approach 3 green, held while preempt=1 beyond 48 cycles.
